// File: rtl/dmem_io_bus_if.sv
// Core data-bus bundle between the RISC-V core (master) and dmem_io_bus (slave).
interface dmem_io_bus_if;
  logic        we;
  logic [3:0]  be;
  logic [31:0] a;
  logic [31:0] wd;
  logic [31:0] rd;

  modport master (output we, output be, output a, output wd, input rd);
  modport slave  (input we, input be, input a, input wd, output rd);
endinterface

// File: rtl/dmem_io_bus.sv
// Data memory and I/O ports for the single-cycle core.
// Combinational reads, rising-edge writes, fixed memory map:
//   0x1000-0x17FF RAM (aliased), 0x7F00+4i IN[i], 0x7F80+4j OUT[j],
//   0x7FF0 STATUS (W1C), 0x7FF4 MASK.
// Optional feature macro: DMEM_IO_EDGE_IRQ_EN enables change detection,
// STATUS, MASK and irq; when undefined those are absent and irq is 0.
module dmem_io_bus #(
  parameter int unsigned RAM_AW = 4,
  parameter int unsigned NIN    = 2,
  parameter int unsigned NOUT   = 2,
  parameter int unsigned IW     = 16,
  parameter int unsigned OW     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  dmem_io_bus_if.slave         bus,
  input  logic [NIN*IW-1:0]    in_ports,
  output logic [NOUT*OW-1:0]   out_ports,
  output logic                 irq
);

  localparam int unsigned RAM_DEPTH = 1 << RAM_AW;

  function automatic logic [31:0] merge(input logic [31:0] old_v,
                                        input logic [31:0] new_v,
                                        input logic [31:0] m);
    return (old_v & ~m) | (new_v & m);
  endfunction

  logic [31:0] wmask;
  logic [4:0]  port_idx;
  logic        wr_ok;
  logic        ram_hit;
  logic        in_hit;
  logic        out_hit;
  logic [31:0] rd_c;
  logic        unused_addr_lsb;

  assign wmask    = {{8{bus.be[3]}}, {8{bus.be[2]}}, {8{bus.be[1]}}, {8{bus.be[0]}}};
  assign port_idx = bus.a[6:2];
  assign wr_ok    = bus.we && !reset;
  assign ram_hit  = (bus.a[31:11] == 21'h2);
  assign in_hit   = (bus.a[31:7] == 25'hFE) && (32'(port_idx) < NIN);
  assign out_hit  = (bus.a[31:7] == 25'hFF) && (32'(port_idx) < NOUT);
  assign unused_addr_lsb = ^bus.a[1:0];

  // RAM storage, byte-lane writes, contents not reset
  logic [31:0] mem_q [RAM_DEPTH];

  // Commit RAM writes lane by lane
  always_ff @(posedge clk) begin
    if (wr_ok && ram_hit) begin
      for (int unsigned k = 0; k < 4; k++) begin
        if (bus.be[k]) mem_q[bus.a[RAM_AW+1:2]][k*8 +: 8] <= bus.wd[k*8 +: 8];
      end
    end
  end

  // Output port registers
  logic [OW-1:0] out_q [NOUT];
  logic [OW-1:0] out_d [NOUT];

  // Next-state for OUT registers: be-masked merge, upper bits beyond OW dropped
  always_comb begin
    for (int unsigned j = 0; j < NOUT; j++) begin
      out_d[j] = out_q[j];
      if (wr_ok && out_hit && (32'(port_idx) == j))
        out_d[j] = OW'(merge(32'(out_q[j]), bus.wd, wmask));
    end
  end

  // OUT register update with synchronous reset
  always_ff @(posedge clk) begin
    for (int unsigned j = 0; j < NOUT; j++) begin
      if (reset) out_q[j] <= '0;
      else       out_q[j] <= out_d[j];
    end
  end

  // Flatten OUT registers onto the output bus
  always_comb begin
    out_ports = '0;
    for (int unsigned j = 0; j < NOUT; j++) out_ports[j*OW +: OW] = out_q[j];
  end

  // Two-flop input synchroniser
  logic [NIN*IW-1:0] s1_q;
  logic [NIN*IW-1:0] s2_q;

  // Synchroniser flops
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= in_ports;
      s2_q <= s1_q;
    end
  end

`ifdef DMEM_IO_EDGE_IRQ_EN
  logic [NIN*IW-1:0] s3_q;
  logic [NIN-1:0]    status_q;
  logic [NIN-1:0]    status_d;
  logic [NIN-1:0]    mask_q;
  logic [NIN-1:0]    mask_d;
  logic [NIN-1:0]    chg;
  logic [NIN-1:0]    clr;
  logic              status_hit;
  logic              mask_hit;

  assign status_hit = (bus.a[31:2] == 30'h1FFC);
  assign mask_hit   = (bus.a[31:2] == 30'h1FFD);

  // Change detect and STATUS/MASK next-state; a same-edge set beats the W1C clear
  always_comb begin
    chg = '0;
    for (int unsigned i = 0; i < NIN; i++)
      chg[i] = (s2_q[i*IW +: IW] != s3_q[i*IW +: IW]);
    clr      = (wr_ok && status_hit) ? bus.wd[NIN-1:0] : '0;
    status_d = (status_q & ~clr) | chg;
    mask_d   = mask_q;
    if (wr_ok && mask_hit) mask_d = NIN'(merge(32'(mask_q), bus.wd, wmask));
  end

  // Previous-value flop, STATUS and MASK registers
  always_ff @(posedge clk) begin
    if (reset) begin
      s3_q     <= '0;
      status_q <= '0;
      mask_q   <= '0;
    end else begin
      s3_q     <= s2_q;
      status_q <= status_d;
      mask_q   <= mask_d;
    end
  end

  assign irq = |(status_q & mask_q);
`else
  assign irq = 1'b0;
`endif

  // Combinational read mux; unmapped addresses return 0
  always_comb begin
    rd_c = '0;
    if (ram_hit) begin
      rd_c = mem_q[bus.a[RAM_AW+1:2]];
    end else if (in_hit) begin
      for (int unsigned i = 0; i < NIN; i++)
        if (32'(port_idx) == i) rd_c = 32'(s2_q[i*IW +: IW]);
    end else if (out_hit) begin
      for (int unsigned j = 0; j < NOUT; j++)
        if (32'(port_idx) == j) rd_c = 32'(out_q[j]);
    end
`ifdef DMEM_IO_EDGE_IRQ_EN
    else if (status_hit) begin
      rd_c = 32'(status_q);
    end else if (mask_hit) begin
      rd_c = 32'(mask_q);
    end
`endif
  end

  assign bus.rd = rd_c;

endmodule

// File: tb/tb_dmem_io_bus.sv
// Directed self-checking bench for dmem_io_bus (default parameters).
module tb_dmem_io_bus;

  logic        clk;
  logic        reset;
  logic [31:0] in_ports;
  logic [31:0] out_ports;
  logic        irq;
  int          checks;
  int          errors;

  dmem_io_bus_if bus ();

  dmem_io_bus #(.RAM_AW(4), .NIN(2), .NOUT(2), .IW(16), .OW(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .in_ports  (in_ports),
    .out_ports (out_ports),
    .irq       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    bus.a = addr;
    #1;
    check(tag, bus.rd, exp);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] lanes);
    bus.we = 1'b1;
    bus.a  = addr;
    bus.wd = data;
    bus.be = lanes;
    tick();
    bus.we = 1'b0;
    bus.be = 4'h0;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    reset    = 1'b1;
    in_ports = '0;
    bus.we   = 1'b0;
    bus.be   = 4'h0;
    bus.a    = 32'h0;
    bus.wd   = 32'h0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    check("rst_out_ports", out_ports, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    rd_chk("rst_out0", 32'h7F80, 32'h0);
    rd_chk("rst_status", 32'h7FF0, 32'h0);

    // RAM byte lanes and aliasing
    wr(32'h1004, 32'hAABBCCDD, 4'hF);
    wr(32'h1004, 32'h00001122, 4'h3);
    rd_chk("ram_lanes", 32'h1004, 32'hAABB1122);
    rd_chk("ram_alias", 32'h1044, 32'hAABB1122);

    // Read during write sees old data until the edge
    bus.we = 1'b1; bus.a = 32'h1004; bus.wd = 32'hFFFFFFFF; bus.be = 4'hF;
    #1;
    check("ram_rdw_old", bus.rd, 32'hAABB1122);
    tick();
    bus.we = 1'b0; bus.be = 4'h0;
    check("ram_rdw_new", bus.rd, 32'hFFFFFFFF);

    // OUT ports
    wr(32'h7F84, 32'h12345678, 4'hF);
    check("out1_port", out_ports, 32'h56780000);
    rd_chk("out1_read", 32'h7F84, 32'h00005678);
    wr(32'h7F84, 32'h0000AB00, 4'h2);
    rd_chk("out1_lane", 32'h7F84, 32'h0000AB78);
    wr(32'h7F80, 32'h0000BEEF, 4'hF);
    check("out_both", out_ports, 32'hAB78BEEF);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("out_reset", out_ports, 32'h0);

`ifdef DMEM_IO_EDGE_IRQ_EN
    wr(32'h7FF4, 32'h00000001, 4'hF);
    rd_chk("mask_set", 32'h7FF4, 32'h1);
`endif

    // IN synchroniser latency
    in_ports = 32'h000000A5;
    tick();
    rd_chk("in0_edge1", 32'h7F00, 32'h0);
    tick();
    rd_chk("in0_edge2", 32'h7F00, 32'h000000A5);
    rd_chk("in1_zero", 32'h7F04, 32'h0);
    rd_chk("in2_unmapped", 32'h7F08, 32'h0);
    rd_chk("status_edge2", 32'h7FF0, 32'h0);
    check("irq_edge2", {31'b0, irq}, 32'h0);
    tick();
`ifdef DMEM_IO_EDGE_IRQ_EN
    rd_chk("status_edge3", 32'h7FF0, 32'h1);
    check("irq_edge3", {31'b0, irq}, 32'h1);
    wr(32'h7FF0, 32'h00000001, 4'h0);
    rd_chk("status_w1c", 32'h7FF0, 32'h0);
    check("irq_w1c", {31'b0, irq}, 32'h0);
`else
    rd_chk("status_off", 32'h7FF0, 32'h0);
    check("irq_off", {31'b0, irq}, 32'h0);
`endif

    // IN[1] change sets STATUS bit 1 (masked off, so no irq)
    in_ports = 32'h000100A5;
    tick(); tick(); tick();
`ifdef DMEM_IO_EDGE_IRQ_EN
    rd_chk("status_bit1", 32'h7FF0, 32'h2);
    check("irq_masked", {31'b0, irq}, 32'h0);
`else
    rd_chk("status_bit1_off", 32'h7FF0, 32'h0);
`endif

    // Set-vs-clear collision: W1C lands on the detecting edge
    in_ports = 32'h000200A5;
    tick(); tick();
    wr(32'h7FF0, 32'h00000002, 4'hF);
`ifdef DMEM_IO_EDGE_IRQ_EN
    rd_chk("collision_set_wins", 32'h7FF0, 32'h2);
    wr(32'h7FF0, 32'h00000002, 4'hF);
    rd_chk("status_clr_bit1", 32'h7FF0, 32'h0);
    wr(32'h7FF4, 32'hFFFFFFFF, 4'h0);
    rd_chk("mask_no_lanes", 32'h7FF4, 32'h1);
    wr(32'h7FF4, 32'hFFFFFFFF, 4'h1);
    rd_chk("mask_nin_bits", 32'h7FF4, 32'h3);
`else
    rd_chk("collision_off", 32'h7FF0, 32'h0);
    wr(32'h7FF4, 32'hFFFFFFFF, 4'hF);
    rd_chk("mask_off", 32'h7FF4, 32'h0);
    check("irq_off_end", {31'b0, irq}, 32'h0);
`endif
    rd_chk("in1_value", 32'h7F04, 32'h00000002);

    // Unmapped accesses
    rd_chk("unmapped_rd", 32'h2000, 32'h0);
    wr(32'h7FF8, 32'hFFFFFFFF, 4'hF);
    check("unmapped_wr_out", out_ports, 32'h0);
    rd_chk("unmapped_wr_ram", 32'h1004, 32'hFFFFFFFF);
    rd_chk("unmapped_wr_rd", 32'h7FF8, 32'h0);
`ifdef DMEM_IO_EDGE_IRQ_EN
    rd_chk("unmapped_wr_mask", 32'h7FF4, 32'h3);
`endif

    // Reset during a write to OUT[0] and to RAM
    reset = 1'b1;
    wr(32'h7F80, 32'h00001234, 4'hF);
    wr(32'h1004, 32'h00000000, 4'hF);
    reset = 1'b0;
    check("rst_mid_write_port", out_ports, 32'h0);
    rd_chk("rst_mid_write_read", 32'h7F80, 32'h0);
    rd_chk("rst_ram_write_ign", 32'h1004, 32'hFFFFFFFF);
    rd_chk("rst_in_cleared", 32'h7F00, 32'h0);
    check("rst_irq_end", {31'b0, irq}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
